// File: rtl/a_io_l3_in_serialize_a_m_axi_wr_burst_split_pkg.sv
// Shared constants and elaboration helpers for the m_axi write burst splitter.
package a_io_l3_in_serialize_a_m_axi_wr_burst_split_pkg;

  localparam int unsigned DEF_BOUNDARY      = 4096;
  localparam int unsigned DEF_MAX_BURST_LEN = 16;
  localparam int unsigned LEN_FIFO_WIDTH    = 9;

  typedef enum logic {
    AW_IDLE  = 1'b0,
    AW_ISSUE = 1'b1
  } aw_state_e;

  function automatic int unsigned bytes_per_beat(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned log2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/a_io_l3_in_serialize_a_m_axi_wr_burst_split_fifo.sv
// Small synchronous FIFO with registered full/empty flags and a
// combinational head read, used to hold outstanding burst beat counts.
module A_IO_L3_in_serialize_A_m_axi_fifo #(
  parameter int DATA_WIDTH = 9,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_n_q, empty_n_q;
  logic                  do_write, do_read;

  assign do_write   = if_write & full_n_q;
  assign do_read    = if_read & empty_n_q;
  assign if_full_n  = full_n_q;
  assign if_empty_n = empty_n_q;
  assign if_dout    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q + CNT_W'(do_write) - CNT_W'(do_read);
  end

  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= if_din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
    end else begin
      if (do_write) wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_read)  rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_q   <= count_d;
      // Flags follow the next occupancy so they are plain flops at the ports.
      full_n_q  <= (count_d != CNT_W'(DEPTH));
      empty_n_q <= (count_d != '0);
    end
  end

endmodule

// File: rtl/a_io_l3_in_serialize_a_m_axi_wr_burst_split.sv
// Splits one user write request into legal AXI bursts (length cap, no
// boundary crossing) and frames the write data stream with WLAST.
module a_io_l3_in_serialize_a_m_axi_wr_burst_split
  import a_io_l3_in_serialize_a_m_axi_wr_burst_split_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 32,
  parameter int MAX_BURST_LEN = DEF_MAX_BURST_LEN,
  parameter int BOUNDARY      = DEF_BOUNDARY,
  parameter int MAXREQS       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic [ADDR_WIDTH-1:0]   in_REQ_ADDR,
  input  logic [LEN_WIDTH-1:0]    in_REQ_LEN,
  input  logic                    in_REQ_VALID,
  output logic                    out_REQ_READY,
  input  logic [DATA_WIDTH-1:0]   in_DATA_DIN,
  input  logic [DATA_WIDTH/8-1:0] in_DATA_STRB,
  input  logic                    in_DATA_VALID,
  output logic                    out_DATA_READY,
  output logic [ADDR_WIDTH-1:0]   out_TOP_AWADDR,
  output logic [7:0]              out_TOP_AWLEN,
  output logic                    out_TOP_AWVALID,
  input  logic                    in_TOP_AWREADY,
  output logic [DATA_WIDTH-1:0]   out_TOP_WDATA,
  output logic [DATA_WIDTH/8-1:0] out_TOP_WSTRB,
  output logic                    out_TOP_WLAST,
  output logic                    out_TOP_WVALID,
  input  logic                    in_TOP_WREADY
);

  localparam int BPB   = int'(bytes_per_beat(DATA_WIDTH));
  localparam int OFF_W = int'(log2(BPB));
  localparam int BND_W = int'(log2(BOUNDARY)) + 1;
  localparam int SUM_W = LEN_WIDTH + 1;

  // Beats in the next burst: capped by remaining, max length and distance to boundary.
  function automatic logic [8:0] calc_burst(input logic [BND_W-2:0]     offset,
                                            input logic [LEN_WIDTH-1:0] rem);
    logic [BND_W-1:0] to_bnd;
    logic [SUM_W-1:0] b;
    to_bnd = BND_W'(BOUNDARY) - {1'b0, offset};
    to_bnd = to_bnd >> OFF_W;
    b = {1'b0, rem};
    if (b > SUM_W'(MAX_BURST_LEN)) b = SUM_W'(MAX_BURST_LEN);
    if (b > SUM_W'(to_bnd))        b = SUM_W'(to_bnd);
    return 9'(b);
  endfunction

  aw_state_e             state_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q, aligned_addr, step_addr, load_addr;
  logic [LEN_WIDTH-1:0]  rem_q, step_rem, load_rem;
  logic [8:0]            burst_q, load_burst;
  logic [7:0]            awlen_q;
  logic [8:0]            beat_cnt_q, head_len;
  logic                  fifo_full_n, fifo_empty_n;
  logic                  req_hs, aw_hs, w_hs, w_pop;

  assign out_REQ_READY   = (state_q == AW_IDLE);
  assign out_TOP_AWVALID = (state_q == AW_ISSUE) & fifo_full_n;
  assign out_TOP_AWADDR  = cur_addr_q;
  assign out_TOP_AWLEN   = awlen_q;

  assign req_hs = in_REQ_VALID & out_REQ_READY & clk_en;
  assign aw_hs  = out_TOP_AWVALID & in_TOP_AWREADY & clk_en;

  // W beats flow only for bursts whose AW has already been accepted.
  assign out_TOP_WDATA  = in_DATA_DIN;
  assign out_TOP_WSTRB  = in_DATA_STRB;
  assign out_TOP_WVALID = in_DATA_VALID & fifo_empty_n;
  assign out_DATA_READY = in_TOP_WREADY & fifo_empty_n;
  assign out_TOP_WLAST  = fifo_empty_n & (beat_cnt_q == head_len - 9'd1);
  assign w_hs           = in_DATA_VALID & in_TOP_WREADY & fifo_empty_n & clk_en;
  assign w_pop          = w_hs & out_TOP_WLAST;

  always_comb begin
    aligned_addr = in_REQ_ADDR & ~ADDR_WIDTH'(BPB - 1);
    step_addr    = cur_addr_q + (ADDR_WIDTH'(burst_q) << OFF_W);
    step_rem     = rem_q - LEN_WIDTH'(burst_q);
    load_addr    = step_addr;
    load_rem     = step_rem;
    if (state_q == AW_IDLE) begin
      load_addr = aligned_addr;
      load_rem  = in_REQ_LEN;
    end
    load_burst = calc_burst(load_addr[BND_W-2:0], load_rem);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= AW_IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      burst_q    <= '0;
      awlen_q    <= '0;
      beat_cnt_q <= '0;
    end else if (clk_en) begin
      // The next burst is precomputed so AW runs back-to-back from flops.
      if (req_hs || aw_hs) begin
        cur_addr_q <= load_addr;
        rem_q      <= load_rem;
        burst_q    <= load_burst;
        awlen_q    <= 8'(load_burst - 9'd1);
      end
      if (req_hs && (in_REQ_LEN != '0)) state_q <= AW_ISSUE;
      if (aw_hs && (step_rem == '0))    state_q <= AW_IDLE;
      if (w_hs) beat_cnt_q <= w_pop ? 9'd0 : beat_cnt_q + 9'd1;
    end
  end

  A_IO_L3_in_serialize_A_m_axi_fifo #(
    .DATA_WIDTH (LEN_FIFO_WIDTH),
    .DEPTH      (MAXREQS)
  ) u_len_fifo (
    .clk        (clk),
    .reset      (reset),
    .if_write   (aw_hs),
    .if_din     (burst_q),
    .if_full_n  (fifo_full_n),
    .if_read    (w_pop),
    .if_dout    (head_len),
    .if_empty_n (fifo_empty_n)
  );

endmodule

// File: doc/a_io_l3_in_serialize_a_m_axi_wr_burst_split.md
# a_io_l3_in_serialize_a_m_axi_wr_burst_split

Write-side burst splitter for the A_IO_L3_in_serialize_A m_axi adapter. It sits directly upstream of the write throttle and feeds the throttle's TOP AW/W inputs. It accepts one user write request (start address plus length in beats) and a matching data stream. It emits legal AXI bursts: AWLEN ≤ MAX_BURST_LEN-1, no 4 KB crossing, and WLAST on the final beat of every burst.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; a power of two, ≥ 8
- LEN_WIDTH, 32, width of the user request length in beats
- MAX_BURST_LEN, 16, maximum beats per burst (1..256)
- BOUNDARY, 4096, burst-crossing boundary in bytes (power of two)
- MAXREQS, 16, depth of the outstanding-burst-length FIFO

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- clk_en  in  1  state-update enable
- in_REQ_ADDR  in  ADDR_WIDTH  start byte address; the low log2(DATA_WIDTH/8) bits are ignored (treated as 0)
- in_REQ_LEN  in  LEN_WIDTH  total beats
- in_REQ_VALID / out_REQ_READY  in / out  1  request handshake
- in_DATA_DIN  in  DATA_WIDTH  write data
- in_DATA_STRB  in  DATA_WIDTH/8  byte strobes
- in_DATA_VALID / out_DATA_READY  in / out  1  data handshake
- out_TOP_AWADDR  out  ADDR_WIDTH  burst address
- out_TOP_AWLEN  out  8  burst length minus 1
- out_TOP_AWVALID / in_TOP_AWREADY  out / in  1  AW handshake
- out_TOP_WDATA, out_TOP_WSTRB  out  DATA_WIDTH, DATA_WIDTH/8  pass-through of DIN/STRB
- out_TOP_WLAST  out  1  last beat of the current burst
- out_TOP_WVALID / in_TOP_WREADY  out / in  1  W handshake

## Operation
- **Handshake rule.** A handshake occurs when valid & ready & clk_en are all high. No state changes while clk_en = 0.
- **AW FSM states.** IDLE and ISSUE.
- **IDLE.** out_REQ_READY = 1. On a request handshake, latch the aligned address into cur_addr and the length into remaining.
  - Go to ISSUE if length ≠ 0.
  - Otherwise stay in IDLE; the request is dropped with no AW and no W.
- **ISSUE.** Compute the burst:
  - beats_to_bnd = (BOUNDARY − (cur_addr mod BOUNDARY)) / (DATA_WIDTH/8)
  - burst = min(remaining, MAX_BURST_LEN, beats_to_bnd)
  - out_TOP_AWADDR = cur_addr; out_TOP_AWLEN = burst − 1
  - out_TOP_AWVALID = len FIFO not full
- **On AW handshake.**
  - Push burst into the len FIFO.
  - cur_addr += burst·(DATA_WIDTH/8), computed at ADDR_WIDTH with wrap.
  - remaining −= burst.
  - If remaining becomes 0, go to IDLE.
- **Width rules.** burst arithmetic uses LEN_WIDTH+1 bits; beats_to_bnd uses log2(BOUNDARY)+1 bits.
- **W path, gating.** Gated by the len FIFO:
  - out_TOP_WVALID = in_DATA_VALID & fifo_nonempty
  - out_DATA_READY = in_TOP_WREADY & fifo_nonempty
- **W path, beat counting.** beat_cnt counts W handshakes.
  - out_TOP_WLAST = (beat_cnt == head_len − 1).
  - A WLAST handshake pops the FIFO and clears beat_cnt.
- **Data ordering.** W beats never precede their AW handshake.

## Timing
- **Reset values.** out_REQ_READY = 1; out_TOP_AWVALID = 0; out_TOP_WVALID = 0; out_DATA_READY = 0; out_TOP_WLAST = 0; out_TOP_AWADDR and out_TOP_AWLEN = 0. FSM in IDLE, FIFO empty, beat_cnt = 0.
- **Request to first AW.** Request handshake in cycle N; out_TOP_AWVALID = 1 in cycle N+1 (all AW outputs registered).
- **Back-to-back AW.** AW bursts run back-to-back: AWVALID stays high across a handshake and the new ADDR/LEN appear the next cycle.
- **AW stall.** While AWVALID = 1 and AWREADY = 0, ADDR/LEN are held stable.
- **Return to IDLE.** After the final AW handshake, out_REQ_READY = 1 the next cycle. The next request may be accepted before the outstanding W beats drain.
- **W path latency.** The W path is combinational pass-through, zero latency; the data becomes valid the cycle after the burst's AW handshake, via the FIFO's registered empty flag.
- **FIFO full.** The AW side stalls with AWVALID = 0.
- **FIFO empty.** The W side stalls.
- **Simultaneous push and pop.** Both are legal in the same cycle.
- **Reset mid-operation.** All state is cleared next cycle; outstanding bursts and beats are discarded.

## Structure
- Shared package holds the adapter constants: the BOUNDARY default, MAX_BURST_LEN default, and the bytes-per-beat and log2 helper.
- One sub-module: the len FIFO is an instance of the adapter's existing A_IO_L3_in_serialize_A_m_axi_fifo.
  - DATA_WIDTH 9, DEPTH MAXREQS.
  - It stores the burst beat count.

## Test plan
- **Simple split.** DATA_WIDTH 32, addr 0x000, len 40, AWREADY/WREADY tied high → AW (0x000,15), (0x040,15), (0x080,7) on consecutive cycles; WLAST exactly on beats 16, 32 and 40.
- **4 KB crossing.** addr 0xFF8, len 8 → AW (0xFF8,1), (0x1000,5); WLAST on beats 2 and 8.
- **AW stall.** AWREADY low 5 cycles on the first burst → AWADDR/AWLEN constant, out_REQ_READY = 0, no W beats issued.
- **Len FIFO full.** MAXREQS 4, WREADY low, len 128 → exactly 4 AW handshakes, then AWVALID = 0. Releasing WREADY for 16 beats lets exactly one more AW issue.
- **Zero length.** len 0 → request accepted, no AW, no W, out_REQ_READY = 1 the next cycle.
- **Reset mid-burst.** Assert reset during beat 7 of a 16-beat burst → next cycle all outputs at reset values. A fresh request then produces correct AW/W from beat 1.
